// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: scheduler state encoding, default address width
// and Gray/binary conversion helpers (operate on up to 32-bit values, zero-extended).
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;
    localparam int GW            = 32;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } rd_state_t;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set req bit searching upward from last+1,
// wrapping. Shared by the read- and write-side schedulers.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_id
);

    logic           found;
    logic [IDW-1:0] sel;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        sel    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sel = IDW'((int'(last) + i) % NREQ);
            if (!found && req[sel]) begin
                found       = 1'b1;
                win[sel]    = 1'b1;
                win_id      = sel;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Async FIFO read-domain controller: read pointer, registered empty flag and a
// round-robin bounded-burst pop scheduler. Optional occupancy output: FIFO_RD_SCHED_LEVEL_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester after last winner
// OWN   | owner holds the read port for up to BURST consecutive pops
module fifo_rd_sched
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE,
    parameter int NREQ     = 4,
    parameter int BURST    = 4,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    output logic [IDW-1:0]      gnt_id,
    output logic                rinc,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
`ifdef FIFO_RD_SCHED_LEVEL_EN
    output logic [ADDRSIZE:0]   rlevel,
`endif
    output logic                rempty
);

    localparam int PW = ADDRSIZE + 1;
    localparam int CW = $clog2(BURST + 1);

    rd_state_t       state, state_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  last, last_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [PW-1:0]   rbin, rbinnext, rgraynext;
    logic [NREQ-1:0] pick_win;
    logic [IDW-1:0]  pick_id;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .last   (last),
        .win    (pick_win),
        .win_id (pick_id)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grants are gated by the registered rempty, so a pop never outruns the data.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        gnt       = '0;
        gnt_id    = '0;
        cnt_inc   = cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!rempty && (|req)) begin
                    gnt       = pick_win;
                    gnt_id    = pick_id;
                    owner_nxt = pick_id;
                    last_nxt  = pick_id;
                    cnt_nxt   = CW'(1);
                    if (BURST > 1) begin
                        state_nxt = OWN;
                    end
                end
            end
            OWN: begin
                if (req[owner]) begin
                    if (!rempty) begin
                        gnt[owner] = 1'b1;
                        gnt_id     = owner;
                        cnt_nxt    = cnt_inc;
                        if (cnt_inc == CW'(BURST)) begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rinc      = |gnt;
    assign rbinnext  = rbin + PW'(rinc);
    assign rgraynext = PW'(bin2gray(GW'(rbinnext)));
    assign raddr     = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
        end
    end

`ifdef FIFO_RD_SCHED_LEVEL_EN
    logic [PW-1:0] wbin_sync;

    assign wbin_sync = PW'(gray2bin(GW'(rq2_wptr)));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel <= '0;
        end else begin
            rlevel <= wbin_sync - rbinnext;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Self-checking bench for fifo_rd_sched (ADDRSIZE=4, NREQ=4, BURST=4).
module tb_fifo_rd_sched;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       rinc;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
`ifdef FIFO_RD_SCHED_LEVEL_EN
    logic [4:0] rlevel;
`endif

    always #5 rclk = ~rclk;

    fifo_rd_sched #(
        .ADDRSIZE (4),
        .NREQ     (4),
        .BURST    (4)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rq2_wptr (rq2_wptr),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .rinc     (rinc),
        .raddr    (raddr),
        .rptr     (rptr),
`ifdef FIFO_RD_SCHED_LEVEL_EN
        .rlevel   (rlevel),
`endif
        .rempty   (rempty)
    );

    typedef struct {
        logic [4:0] wbin;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       empty;
        logic [4:0] rbin;
    } vec_t;

    vec_t       vecs[$];
    vec_t       sb[$];
    logic [4:0] sb_rptr[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int onehot_id(input logic [3:0] v);
        int id;
        id = 0;
        for (int i = 0; i < 4; i++) begin
            if (((v >> i) & 4'd1) != 4'd0) id = i;
        end
        return id;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic [4:0] wbin, input logic [3:0] rq, input logic [3:0] gn,
                       input logic em, input logic [4:0] rb);
        vec_t v;
        v.wbin = wbin; v.req = rq; v.gnt = gn; v.empty = em; v.rbin = rb;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n   = 1'b0;
        req      = '0;
        rq2_wptr = '0;
        @(negedge rclk);
        rrst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        vec_t       e;
        logic [4:0] rb;
        logic [4:0] prev;
        int         pops;

        rrst_n   = 1'b0;
        req      = '0;
        rq2_wptr = '0;

        // empty after reset despite all requests
        for (int i = 0; i < 10; i++) add(5'd0, 4'hF, 4'h0, 1'b1, 5'd0);
        // 8 entries: owner 0 bursts 4, then owner 1 bursts 4, then empty
        add(5'd8, 4'hF, 4'h0, 1'b1, 5'd0);
        for (int i = 0; i < 4; i++) add(5'd8, 4'hF, 4'h1, 1'b0, 5'(i));
        for (int i = 4; i < 8; i++) add(5'd8, 4'hF, 4'h2, 1'b0, 5'(i));
        add(5'd8, 4'hF, 4'h0, 1'b1, 5'd8);
        // owner 0 drops after 2 pops: idle cycle, then 2 bursts
        add(5'd24, 4'h1, 4'h0, 1'b1, 5'd8);
        add(5'd24, 4'h1, 4'h1, 1'b0, 5'd8);
        add(5'd24, 4'h5, 4'h1, 1'b0, 5'd9);
        add(5'd24, 4'h4, 4'h0, 1'b0, 5'd10);
        for (int i = 10; i < 14; i++) add(5'd24, 4'h4, 4'h4, 1'b0, 5'(i));
        add(5'd24, 4'h4, 4'h4, 1'b0, 5'd14);
        add(5'd24, 4'h0, 4'h0, 1'b0, 5'd15);

        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge rclk);
            rq2_wptr = g(vecs[k].wbin);
            req      = vecs[k].req;
            sb.push_back(vecs[k]);
            #1;
            e = sb.pop_front();
            chk("vec_gnt",    int'(gnt),    int'(e.gnt));
            chk("vec_gnt_id", int'(gnt_id), onehot_id(e.gnt));
            chk("vec_rinc",   int'(rinc),   int'(|e.gnt));
            chk("vec_rempty", int'(rempty), int'(e.empty));
            chk("vec_rptr",   int'(rptr),   int'(g(e.rbin)));
            chk("vec_raddr",  int'(raddr),  int'(e.rbin[3:0]));
        end

        // single entry: pop, empty, resume with owner 1 and cnt held at 1
        do_reset();
        req      = 4'b0010;
        @(negedge rclk);
        rq2_wptr = g(5'd1);
        #1 chk("single_wait", int'(gnt), 0);
        @(negedge rclk);
        #1 chk("single_pop", int'(gnt), 4'b0010);
        @(negedge rclk);
        #1 chk("single_empty_flag", int'(rempty), 1);
        chk("single_empty_gnt", int'(gnt), 0);
        @(negedge rclk);
        rq2_wptr = g(5'd10);
        req      = 4'b0011;
        #1 chk("resume_wait", int'(gnt), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            #1 chk("resume_own", int'(gnt), 4'b0010);
        end
        @(negedge rclk);
        #1 chk("resume_rotate", int'(gnt), 4'b0001);
        chk("resume_rptr", int'(rptr), int'(g(5'd4)));

        // asynchronous reset in the middle of a burst
        do_reset();
        rq2_wptr = g(5'd8);
        req      = 4'hF;
        @(negedge rclk);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            #1 chk("burst_pre_reset", int'(gnt), 4'b0001);
        end
        #2 rrst_n = 1'b0;
        #1 chk("rst_gnt", int'(gnt), 0);
        chk("rst_rinc", int'(rinc), 0);
        chk("rst_rempty", int'(rempty), 1);
        chk("rst_rptr", int'(rptr), 0);
        req = 4'b1010;
        @(negedge rclk);
        rrst_n = 1'b1;
        #1 chk("post_rst_empty_gnt", int'(gnt), 0);
        @(negedge rclk);
        #1 chk("post_rst_first", int'(gnt), 4'b0010);
        chk("post_rst_first_id", int'(gnt_id), 1);

        // wrap: 40 pops with the write pointer kept ahead
        do_reset();
        req  = 4'hF;
        rb   = '0;
        prev = '0;
        pops = 0;
        for (int c = 0; c < 60 && pops < 40; c++) begin
            @(negedge rclk);
            rq2_wptr = g(rb + 5'd3);
            #1;
            if (rempty) chk("wrap_no_gnt_empty", int'(gnt), 0);
            if (gnt != 4'h0) begin
                rb   = rb + 5'd1;
                pops++;
            end
            sb_rptr.push_back(g(rb));
            @(posedge rclk);
            #1;
            chk("wrap_rptr", int'(rptr), int'(sb_rptr.pop_front()));
            if (rptr != prev) chk("wrap_gray_step", $countones(rptr ^ prev), 1);
            prev = rptr;
        end
        chk("wrap_pop_count", pops, 40);
        chk("wrap_final_rptr", int'(rptr), int'(g(5'd8)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
